// File: rtl/fpu_muldiv_arbiter_if.sv
// Signal bundle between the two FPU requesters, the arbiter and the shared mul/div unit.
// The arbiter side uses modport slave; requesters plus the unit sit on modport master.
`default_nettype none
interface fpu_muldiv_arbiter_if;
    logic        req0, req1;
    logic [15:0] opX0, opX1, opY0, opY1;
    logic        opDiv0, opDiv1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] res0, res1;
    logic [1:0]  flags0, flags1;
    logic [15:0] mdX, mdY;
    logic        mdMulOrDiv, mdReset;
    logic [15:0] mdResult;
    logic [1:0]  mdOFUF;
    logic        mdDone;
    logic        busy, lastGrant, timeoutErr;

    modport slave (
        input  req0, req1, opX0, opX1, opY0, opY1, opDiv0, opDiv1,
        input  mdResult, mdOFUF, mdDone,
        output gnt0, gnt1, done0, done1, res0, res1, flags0, flags1,
        output mdX, mdY, mdMulOrDiv, mdReset, busy, lastGrant, timeoutErr
    );

    modport master (
        output req0, req1, opX0, opX1, opY0, opY1, opDiv0, opDiv1,
        output mdResult, mdOFUF, mdDone,
        input  gnt0, gnt1, done0, done1, res0, res1, flags0, flags1,
        input  mdX, mdY, mdMulOrDiv, mdReset, busy, lastGrant, timeoutErr
    );
endinterface
`default_nettype wire

// File: rtl/fpu_muldiv_arbiter.sv
// Round-robin sharing of one half-precision mul/div unit between two requesters.
// Optional RUN-state watchdog enabled by defining FPU_MD_TIMEOUT_EN.
`default_nettype none
module fpu_muldiv_arbiter #(
    parameter int RESET_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    fpu_muldiv_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESPOND} state_t;

    localparam logic [3:0] RC_LAST = 4'(RESET_CYCLES - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              run_first_q, run_first_d;
    logic              last_grant_q, last_grant_d;
    logic [15:0]       md_x_q, md_x_d, md_y_q, md_y_d;
    logic              md_div_q, md_div_d;
    logic              md_reset_q, md_reset_d;
    logic [1:0]        gnt_q, gnt_d, done_q, done_d;
    logic [1:0][15:0]  res_q, res_d;
    logic [1:0][1:0]   flags_q, flags_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic [1:0]        req;
    logic              win;

`ifdef FPU_MD_TIMEOUT_EN
    logic [7:0]        to_cnt_q, to_cnt_d;
`else
    logic              unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LAST;
`endif

    assign req = {bus.req1, bus.req0};

    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        run_first_d  = run_first_q;
        last_grant_d = last_grant_q;
        md_x_d       = md_x_q;
        md_y_d       = md_y_q;
        md_div_d     = md_div_q;
        res_d        = res_q;
        flags_d      = flags_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        terr_d       = 1'b0;
        win          = 1'b0;
`ifdef FPU_MD_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    // Contention goes to whoever was not served last.
                    win          = (req == 2'b11) ? ~last_grant_q : req[1];
                    last_grant_d = win;
                    md_x_d       = win ? bus.opX1 : bus.opX0;
                    md_y_d       = win ? bus.opY1 : bus.opY0;
                    md_div_d     = win ? bus.opDiv1 : bus.opDiv0;
                    gnt_d[win]   = 1'b1;
                    rcnt_d       = 4'd0;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                if (rcnt_q == RC_LAST) begin
                    run_first_d = 1'b1;
`ifdef FPU_MD_TIMEOUT_EN
                    to_cnt_d    = 8'd0;
`endif
                    state_d     = RUN;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            RUN: begin
                run_first_d = 1'b0;
`ifdef FPU_MD_TIMEOUT_EN
                to_cnt_d    = to_cnt_q + 8'd1;
`endif
                // The unit's done level may still be left over from the previous op on entry.
                if (bus.mdDone && !run_first_q) begin
                    res_d[last_grant_q]   = bus.mdResult;
                    flags_d[last_grant_q] = bus.mdOFUF;
                    done_d[last_grant_q]  = 1'b1;
                    state_d               = RESPOND;
                end
`ifdef FPU_MD_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    res_d[last_grant_q]   = 16'h7E00;
                    flags_d[last_grant_q] = 2'b11;
                    done_d[last_grant_q]  = 1'b1;
                    terr_d                = 1'b1;
                    state_d               = RESPOND;
                end
`endif
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        md_reset_d = (state_d != RUN);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rcnt_q       <= 4'd0;
            run_first_q  <= 1'b0;
            last_grant_q <= 1'b1;
            md_x_q       <= 16'd0;
            md_y_q       <= 16'd0;
            md_div_q     <= 1'b0;
            md_reset_q   <= 1'b1;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            res_q        <= '0;
            flags_q      <= '0;
            busy_q       <= 1'b0;
            terr_q       <= 1'b0;
`ifdef FPU_MD_TIMEOUT_EN
            to_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            run_first_q  <= run_first_d;
            last_grant_q <= last_grant_d;
            md_x_q       <= md_x_d;
            md_y_q       <= md_y_d;
            md_div_q     <= md_div_d;
            md_reset_q   <= md_reset_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
            busy_q       <= busy_d;
            terr_q       <= terr_d;
`ifdef FPU_MD_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign bus.gnt0       = gnt_q[0];
    assign bus.gnt1       = gnt_q[1];
    assign bus.done0      = done_q[0];
    assign bus.done1      = done_q[1];
    assign bus.res0       = res_q[0];
    assign bus.res1       = res_q[1];
    assign bus.flags0     = flags_q[0];
    assign bus.flags1     = flags_q[1];
    assign bus.mdX        = md_x_q;
    assign bus.mdY        = md_y_q;
    assign bus.mdMulOrDiv = md_div_q;
    assign bus.mdReset    = md_reset_q;
    assign bus.busy       = busy_q;
    assign bus.lastGrant  = last_grant_q;
    assign bus.timeoutErr = terr_q;
endmodule
`default_nettype wire

// File: tb/tb_fpu_muldiv_arbiter.sv
// Scoreboard bench for fpu_muldiv_arbiter with a behavioural mul/div unit model.
// Expected results are pushed at grant time; a monitor process checks every cycle.
module tb_fpu_muldiv_arbiter;
    localparam int RC = 2;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    fpu_muldiv_arbiter_if bus();

    fpu_muldiv_arbiter #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        port;
        logic [15:0] res;
        logic [1:0]  flags;
        logic        terr;
        int          at;
    } exp_t;
    exp_t sbq[$];

    // Requester plans and unit-model state
    logic [1:0]  req_r = 2'b00;
    logic [15:0] px[2], py[2];
    logic        pd[2];
    int          pdel[2];
    bit          pstale[2];
    bit          pend[2];
    int          u_delay = 2;
    bit          u_stale = 1'b0;
    int          ucnt = 0;

    // Unit behaviour: two fixed cases from the datasheet example, otherwise a simple hash.
    function automatic logic [17:0] unit_f(input logic [15:0] x, input logic [15:0] y, input logic d);
        logic [1:0] f;
        if (x == 16'h4000 && y == 16'h4200 && !d) return {2'b00, 16'h4600};
        if (x == 16'h7BFF && y == 16'h4000 && !d) return {2'b10, 16'h7C00};
        f = (x[3:2] == 2'd0) ? 2'b10 : ((x[3:2] == 2'd1) ? 2'b01 : 2'b00);
        return {f, (x ^ {y[7:0], y[15:8]}) + {15'd0, d}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        bus.req0 = req_r[0]; bus.opX0 = px[0]; bus.opY0 = py[0]; bus.opDiv0 = pd[0];
        bus.req1 = req_r[1]; bus.opX1 = px[1]; bus.opY1 = py[1]; bus.opDiv1 = pd[1];
    endtask

    task automatic request(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic d, input int dl, input bit st);
        px[i] = x; py[i] = y; pd[i] = d; pdel[i] = dl; pstale[i] = st;
        req_r[i] = 1'b1;
        drive();
    endtask

    // One cycle of stimulus: consume grants, advance the unit model, drive inputs.
    task automatic tick();
        logic [17:0] r;
        exp_t e;
        logic g, dn;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            g  = (i == 0) ? bus.gnt0 : bus.gnt1;
            dn = (i == 0) ? bus.done0 : bus.done1;
            if (g && req_r[i]) begin
                r = unit_f(px[i], py[i], pd[i]);
                e.port = (i == 1);
                if (pdel[i] == 0) begin
                    e.res = 16'h7E00; e.flags = 2'b11; e.terr = 1'b1; e.at = cyc + RC + TO;
                end else begin
                    e.res = r[15:0]; e.flags = r[17:16]; e.terr = 1'b0; e.at = cyc + RC + pdel[i];
                end
                sbq.push_back(e);
                req_r[i] = 1'b0;
                pend[i]  = 1'b1;
                u_delay  = pdel[i];
                u_stale  = pstale[i];
            end
            if (dn) pend[i] = 1'b0;
        end
        if (bus.mdReset) begin
            ucnt = 0;
            bus.mdDone = 1'b0;
        end else begin
            ucnt++;
            if (u_stale && ucnt == 1) begin
                bus.mdDone = 1'b1; bus.mdResult = 16'hBAD0; bus.mdOFUF = 2'b01;
            end else if (u_delay != 0 && ucnt >= u_delay) begin
                r = unit_f(bus.mdX, bus.mdY, bus.mdMulOrDiv);
                bus.mdDone = 1'b1; bus.mdResult = r[15:0]; bus.mdOFUF = r[17:16];
            end else begin
                bus.mdDone = 1'b0; bus.mdResult = 16'($urandom); bus.mdOFUF = 2'($urandom_range(0, 2));
            end
        end
        drive();
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((req_r != 2'b00 || pend[0] || pend[1] || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL wait_quiet cyc=%0d actual=busy required=idle within %0d cycles", cyc, budget);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        sbq.delete();
        req_r = 2'b00; pend[0] = 1'b0; pend[1] = 1'b0;
        drive();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'(1'b0));
        chk("rst_mdreset", 32'(bus.mdReset), 32'(1'b1));
        chk("rst_res", {bus.res1, bus.res0}, 32'd0);
        reset = 1'b0;
    endtask

    // Monitor: arbitration model, scoreboard pops and held-output checks.
    initial begin : monitor
        bit         idle_prev, done_prev, idle_now, exp_g;
        logic       last, w;
        logic [1:0] rq, gv, dv, exp_gv;
        logic [15:0] mres[2];
        logic [1:0]  mfl[2];
        logic        exp_terr;
        exp_t        e;
        idle_prev = 1'b1; done_prev = 1'b0; last = 1'b1;
        mres[0] = '0; mres[1] = '0; mfl[0] = '0; mfl[1] = '0;
        forever begin
            @(posedge clk);
            rq = {bus.req1, bus.req0};
            #1;
            if (reset) begin
                chk("reset_gnt_done", {28'd0, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'd0);
                chk("reset_res", {bus.res1, bus.res0}, 32'd0);
                chk("reset_flags", {28'd0, bus.flags1, bus.flags0}, 32'd0);
                chk("reset_md", {bus.mdX, bus.mdY[14:0], bus.mdMulOrDiv}, 32'd0);
                chk("reset_ctl", {28'd0, bus.mdReset, bus.busy, bus.lastGrant, bus.timeoutErr}, 32'b1010);
                idle_prev = 1'b1; done_prev = 1'b0; last = 1'b1;
                mres[0] = '0; mres[1] = '0; mfl[0] = '0; mfl[1] = '0;
                continue;
            end
            exp_g  = idle_prev && (rq != 2'b00);
            w      = (rq == 2'b11) ? ~last : rq[1];
            exp_gv = exp_g ? (w ? 2'b10 : 2'b01) : 2'b00;
            gv     = {bus.gnt1, bus.gnt0};
            chk("gnt", 32'(gv), 32'(exp_gv));
            if (exp_g) last = w;
            idle_now = exp_g ? 1'b0 : (done_prev ? 1'b1 : idle_prev);
            chk("busy", 32'(bus.busy), 32'(!idle_now));
            chk("lastGrant", 32'(bus.lastGrant), 32'(last));
            dv = {bus.done1, bus.done0};
            exp_terr = 1'b0;
            if (dv != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 32'(dv), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_port", 32'(dv), 32'(e.port ? 2'b10 : 2'b01));
                    chk("done_cycle", 32'(cyc), 32'(e.at));
                    mres[e.port] = e.res;
                    mfl[e.port]  = e.flags;
                    exp_terr     = e.terr;
                end
            end
            chk("timeoutErr", 32'(bus.timeoutErr), 32'(exp_terr));
            chk("res", {bus.res1, bus.res0}, {mres[1], mres[0]});
            chk("flags", {28'd0, bus.flags1, bus.flags0}, {28'd0, mfl[1], mfl[0]});
            done_prev = (dv != 2'b00);
            idle_prev = idle_now;
        end
    end

    initial begin : stimulus
        int n, runc;
        px[0] = '0; px[1] = '0; py[0] = '0; py[1] = '0; pd[0] = 1'b0; pd[1] = 1'b0;
        pdel[0] = 2; pdel[1] = 2; pstale[0] = 1'b0; pstale[1] = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
        bus.mdDone = 1'b0; bus.mdResult = '0; bus.mdOFUF = '0;
        drive();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Datasheet example on requester 0
        request(0, 16'h4000, 16'h4200, 1'b0, 3, 1'b0);
        wait_quiet(40);
        chk("example_res0", 32'(bus.res0), 32'h4600);

        // Both requesters held: grants must alternate
        request(0, 16'($urandom), 16'($urandom), 1'b0, 2, 1'b0);
        request(1, 16'($urandom), 16'($urandom), 1'b1, 3, 1'b0);
        for (int t = 0; t < 90; t++) begin
            tick();
            for (int i = 0; i < 2; i++)
                if (!req_r[i] && !pend[i])
                    request(i, 16'($urandom), 16'($urandom), 1'($urandom), 2, 1'b0);
        end
        wait_quiet(60);

        // Overflow result on port 1 only
        request(1, 16'h7BFF, 16'h4000, 1'b0, 2, 1'b0);
        wait_quiet(40);
        chk("ovf_res1", {bus.flags1, bus.res1}, {14'd0, 2'b10, 16'h7C00});

        // Reset two cycles into RUN
        request(1, 16'h3C00, 16'h4400, 1'b1, 12, 1'b0);
        n = 0; runc = 0;
        while (runc < 2 && n < 50) begin
            tick();
            n++;
            if (!bus.mdReset && bus.busy) runc++;
        end
        chk("reached_run", 32'(runc), 32'd2);
        pulse_reset();
        request(0, 16'h4000, 16'h4200, 1'b0, 2, 1'b0);
        wait_quiet(40);

        // Stale done at RUN entry
        request(0, 16'h1234, 16'h5678, 1'b1, 4, 1'b1);
        wait_quiet(40);
        chk("stale_res0", 32'(bus.res0), 32'(unit_f(16'h1234, 16'h5678, 1'b1) & 18'h0FFFF));

        // Randomised traffic, including requests withdrawn before grant
        for (int t = 0; t < 400; t++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!req_r[i] && !pend[i] && $urandom_range(0, 3) == 0)
                    request(i, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(2, 5),
                            1'($urandom_range(0, 1)));
                else if (req_r[i] && $urandom_range(0, 15) == 0) begin
                    req_r[i] = 1'b0;
                    drive();
                end
            end
        end
        wait_quiet(60);

        // Unit never finishes
`ifdef FPU_MD_TIMEOUT_EN
        request(0, 16'h4000, 16'h3C00, 1'b1, 0, 1'b0);
        wait_quiet(40);
        chk("timeout_res0", {bus.flags0, bus.res0}, {14'd0, 2'b11, 16'h7E00});
`else
        request(1, 16'h4000, 16'h3C00, 1'b1, 0, 1'b0);
        repeat (30) tick();
        chk("hang_busy", 32'(bus.busy), 32'(1'b1));
        pulse_reset();
`endif
        request(1, 16'h4000, 16'h4200, 1'b0, 2, 1'b0);
        wait_quiet(40);
        chk("final_res1", 32'(bus.res1), 32'h4600);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
